// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep sequencer and its register interface.
package dds_pkg;

  localparam int DDS_KW = 32;  // DDS frequency word width
  localparam int DDS_PW = 11;  // DDS phase word width
  localparam int DDS_CW = 16;  // step-count / dwell counter width

  // STEP is never occupied on its own: the step is folded into the
  // dwell-expiry edge, so the sequencer goes straight from DWELL to DWELL.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2
  } sweep_state_t;

  // Sweep configuration record, shared with the register interface.
  typedef struct packed {
    logic [DDS_KW-1:0] f_start;
    logic [DDS_KW-1:0] f_step;
    logic [DDS_CW-1:0] step_count;
    logic [DDS_CW-1:0] dwell;
    logic              dir;
    logic              cont;
    logic [DDS_PW-1:0] phase;
  } sweep_cfg_t;

  // Timer reload value: a dwell of 0 behaves like a dwell of 1.
  // The timer counts down to zero, so the reload is one less than the hold time.
  function automatic logic [DDS_CW-1:0] dwell_reload(input logic [DDS_CW-1:0] d);
    return (d == '0) ? '0 : d - DDS_CW'(1);
  endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that paces how long each frequency word is held.
// Expiry is flagged while the count sits at zero; the counter parks there.
module dds_dwell_timer #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expired
);

  logic [CW-1:0] cnt;

  // Load takes priority; otherwise count down and stop at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep sequencer; sole writer of the DDS K and P words.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no sweep running; outputs hold last words, waits for start
//   DWELL | holding current K for the programmed dwell; on expiry it
//         | steps, restarts (continuous) or finishes (single-shot)
//   STEP  | not occupied; the step is applied on the DWELL-expiry edge
//
// The configuration is captured on the accepting start edge so the
// register interface may change its values while a sweep is running.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int KW = DDS_KW,
  parameter int PW = DDS_PW,
  parameter int CW = DDS_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          cont,
  input  logic          dir,
  input  logic [KW-1:0] f_start,
  input  logic [KW-1:0] f_step,
  input  logic [CW-1:0] step_count,
  input  logic [CW-1:0] dwell,
  input  logic [PW-1:0] phase,
  output logic [KW-1:0] K_out,
  output logic [PW-1:0] P_out,
  output logic          k_upd,
  output logic          busy,
  output logic          done
);

  sweep_state_t  state, state_nxt;
  sweep_cfg_t    cfg_q;
  logic [CW-1:0] idx;

  logic          expired;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;

  // Per-edge actions decided by the next-state logic.
  logic          do_start;
  logic          do_step;
  logic          do_restart;
  logic          do_finish;
  logic          do_abort;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and action decode; abort outranks every other event.
  always_comb begin
    state_nxt  = state;
    do_start   = 1'b0;
    do_step    = 1'b0;
    do_restart = 1'b0;
    do_finish  = 1'b0;
    do_abort   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          do_start  = 1'b1;
          state_nxt = DWELL;
        end
      end
      DWELL: begin
        if (abort) begin
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end else if (expired) begin
          if (idx < cfg_q.step_count) begin
            do_step = 1'b1;
          end else if (cfg_q.cont) begin
            do_restart = 1'b1;
          end else begin
            do_finish = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      STEP: begin
        if (abort) begin
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = DWELL;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The timer reloads whenever a new K word is presented. On the start
  // edge the live dwell input is used since the shadow copy is not yet valid.
  assign tmr_load = do_start | do_step | do_restart;
  assign tmr_val  = do_start ? dwell_reload(dwell) : dwell_reload(cfg_q.dwell);

  dds_dwell_timer #(
    .CW (CW)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (expired)
  );

  // Configuration shadow registers, written only on the accepting start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q <= '0;
    end else if (do_start) begin
      cfg_q.f_start    <= f_start;
      cfg_q.f_step     <= f_step;
      cfg_q.step_count <= step_count;
      cfg_q.dwell      <= dwell;
      cfg_q.dir        <= dir;
      cfg_q.cont       <= cont;
      cfg_q.phase      <= phase;
    end
  end

  // Output words, step index and status pulses. K wraps modulo 2^KW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      K_out <= '0;
      P_out <= '0;
      k_upd <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
    end else begin
      k_upd <= 1'b0;
      done  <= 1'b0;
      if (do_start) begin
        K_out <= f_start;
        P_out <= phase;
        k_upd <= 1'b1;
        busy  <= 1'b1;
        idx   <= '0;
      end
      if (do_step) begin
        K_out <= cfg_q.dir ? (K_out - cfg_q.f_step) : (K_out + cfg_q.f_step);
        k_upd <= 1'b1;
        idx   <= idx + CW'(1);
      end
      if (do_restart) begin
        K_out <= cfg_q.f_start;
        k_upd <= 1'b1;
        idx   <= '0;
      end
      if (do_finish) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (do_abort) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for the DDS sweep sequencer. Outputs are sampled on the
// falling clock edge; inputs change there too.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        cont;
  logic        dir;
  logic [31:0] f_start;
  logic [31:0] f_step;
  logic [15:0] step_count;
  logic [15:0] dwell;
  logic [10:0] phase;
  logic [31:0] K_out;
  logic [10:0] P_out;
  logic        k_upd;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  dds_sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cont       (cont),
    .dir        (dir),
    .f_start    (f_start),
    .f_step     (f_step),
    .step_count (step_count),
    .dwell      (dwell),
    .phase      (phase),
    .K_out      (K_out),
    .P_out      (P_out),
    .k_upd      (k_upd),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] fs, input logic [31:0] fst, input logic dr,
                         input logic [15:0] sc, input logic [15:0] dw, input logic [10:0] ph,
                         input logic ct);
    f_start    = fs;
    f_step     = fst;
    dir        = dr;
    step_count = sc;
    dwell      = dw;
    phase      = ph;
    cont       = ct;
  endtask

  // Starts a single-shot sweep and checks every cycle of it against a
  // hand model. At sample number inj a competing start with other settings
  // is pulsed; it must have no effect.
  task automatic expect_sweep(input string name, input logic [31:0] fs, input logic [31:0] fst,
                              input logic dr, input int sc, input int dw,
                              input logic [10:0] ph, input int inj);
    logic [31:0] k;
    int          d;
    int          n;
    set_cfg(fs, fst, dr, sc[15:0], dw[15:0], ph, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d = (dw == 0) ? 1 : dw;
    k = fs;
    n = 0;
    for (int s = 0; s <= sc; s++) begin
      for (int c = 0; c < d; c++) begin
        check($sformatf("%s s%0d c%0d K", name, s, c), K_out, k);
        check($sformatf("%s s%0d c%0d busy", name, s, c), busy, 1);
        check($sformatf("%s s%0d c%0d kupd", name, s, c), k_upd, (c == 0));
        check($sformatf("%s s%0d c%0d done", name, s, c), done, 0);
        check($sformatf("%s s%0d c%0d P", name, s, c), P_out, ph);
        if (n == inj) begin
          set_cfg(32'd999, 32'd1, ~dr, 16'd0, 16'd1, 11'h7ff, 1'b0);
          start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        n++;
      end
      if (s < sc) k = dr ? (k - fst) : (k + fst);
    end
    check({name, " end busy"}, busy, 0);
    check({name, " end done"}, done, 1);
    check({name, " end K"}, K_out, k);
    check({name, " end kupd"}, k_upd, 0);
    @(negedge clk);
    check({name, " post done"}, done, 0);
    check({name, " post busy"}, busy, 0);
    check({name, " post K"}, K_out, k);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    set_cfg(32'd0, 32'd0, 1'b0, 16'd0, 16'd0, 11'd0, 1'b0);
    @(negedge clk);
    check("rst K", K_out, 0);
    check("rst P", P_out, 0);
    check("rst busy", busy, 0);
    check("rst kupd", k_upd, 0);
    check("rst done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    expect_sweep("up", 32'd100, 32'd10, 1'b0, 3, 4, 11'd3, -1);
    expect_sweep("wrap", 32'hFFFF_FFF0, 32'h20, 1'b0, 1, 1, 11'd0, -1);
    expect_sweep("down", 32'd5, 32'd10, 1'b1, 1, 1, 11'd9, -1);
    expect_sweep("dw0", 32'd42, 32'd1, 1'b0, 0, 0, 11'd1, -1);

    // start and abort together while idle: nothing happens
    set_cfg(32'd77, 32'd1, 1'b0, 16'd2, 16'd2, 11'd5, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("sa busy", busy, 0);
    check("sa kupd", k_upd, 0);
    check("sa K", K_out, 42);
    @(negedge clk);
    check("sa busy2", busy, 0);

    // continuous sweep 1,1,2,2,3,3,... then abort on the last cycle of a 2
    set_cfg(32'd1, 32'd1, 1'b0, 16'd2, 16'd2, 11'd4, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("cont i%0d K", i), K_out, 1 + (i / 2) % 3);
      check($sformatf("cont i%0d kupd", i), k_upd, (i % 2 == 0));
      check($sformatf("cont i%0d busy", i), busy, 1);
      check($sformatf("cont i%0d done", i), done, 0);
      if (i == 15) abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    check("abort busy", busy, 0);
    check("abort K", K_out, 2);
    check("abort kupd", k_upd, 0);
    check("abort done", done, 0);
    check("abort P", P_out, 4);
    @(negedge clk);
    check("abort busy2", busy, 0);
    check("abort K2", K_out, 2);

    // competing start during a sweep
    expect_sweep("busy_start", 32'd100, 32'd10, 1'b0, 3, 4, 11'd6, 5);

    // asynchronous reset between edges in the middle of a sweep
    set_cfg(32'd500, 32'd5, 1'b0, 16'd2, 16'd3, 11'd8, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-rst K", K_out, 505);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst K", K_out, 0);
    check("async rst P", P_out, 0);
    check("async rst busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after rst busy", busy, 0);
    expect_sweep("post_rst", 32'd500, 32'd5, 1'b0, 2, 3, 11'd8, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer that drives the frequency word (K) and phase word (P) inputs of the DDS core.
Runs linear frequency sweeps: start word, signed-direction step, programmable step count and per-step dwell time.
Supports single-shot or continuous (auto-restart) operation.
Sits between the control/register interface and the DDS phase accumulator; it is the only writer of K/P.

Parameters:
KW, 32, frequency word width (matches DDS K)
PW, 11, phase word width (matches DDS P)
CW, 16, width of step-count and dwell counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; begins sweep when idle
abort  in  1  one-cycle pulse; terminates sweep
cont  in  1  1 = continuous (restart after last step), 0 = single-shot
dir  in  1  0 = step up (add), 1 = step down (subtract)
f_start  in  KW  first frequency word
f_step  in  KW  step magnitude
step_count  in  CW  number of steps after the first word
dwell  in  CW  clocks each word is held (0 treated as 1)
phase  in  PW  phase offset
K_out  out  KW  frequency word to DDS
P_out  out  PW  phase word to DDS
k_upd  out  1  one-cycle pulse when K_out changes
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at single-shot completion

Behaviour:
- Reset (async, rst=1): state IDLE; K_out=0, P_out=0, k_upd=0, busy=0, done=0; all counters 0.
- Config latch: f_start, f_step, step_count, dwell, dir, cont, phase captured into shadow regs on the edge accepting start; inputs ignored otherwise.
- FSM states: IDLE, DWELL, STEP.
- IDLE: on start=1 (and abort=0) at edge t: K_out<=f_start, P_out<=phase, k_upd<=1, busy<=1, idx<=0, dwell_cnt<=max(dwell,1)-1, go DWELL. start+abort same cycle: abort wins, stay IDLE.
- DWELL: dwell_cnt decrements each cycle; at dwell_cnt==0:
  - idx<step_count: go STEP.
  - idx==step_count, cont=0: done<=1 (one cycle), busy<=0, go IDLE; K_out/P_out hold final value.
  - idx==step_count, cont=1: K_out<=f_start, idx<=0, k_upd<=1, reload dwell_cnt, stay DWELL (seamless restart, no gap cycle).
- STEP: (single cycle, merged into the DWELL-expiry edge: no extra clock) K_out<=K_out±f_step modulo 2^KW (wrap silently, no saturation), idx<=idx+1, k_upd<=1, reload dwell_cnt.
- Timing: each K value is held exactly max(dwell,1) cycles; single-shot busy duration = (step_count+1)*max(dwell,1) cycles; done asserts on the edge busy falls.
- step_count=0: f_start held one dwell period, then done.
- start while busy: ignored (no re-latch).
- abort in any non-IDLE state: next edge busy<=0, go IDLE, done stays 0, k_upd stays 0, K_out/P_out hold current values.
- Reset mid-sweep: immediate return to reset values; DDS sees K=0.
- k_upd never asserts on two consecutive cycles unless dwell<=1.

Decomposition:
- Shared package dds_pkg: KW/PW defaults, state enum (IDLE, DWELL, STEP), sweep-config record type (f_start, f_step, step_count, dwell, dir, cont, phase) also reused by the register interface.
- One natural sub-module: dds_dwell_timer (loadable down-counter, expiry flag), instantiated once.

Test Plan:
- Basic up sweep: f_start=100, f_step=10, step_count=3, dwell=4, cont=0 -> K_out 100,110,120,130 each 4 cycles; k_upd 4 pulses; busy 16 cycles; done pulse on cycle 16; K_out stays 130.
- Wrap/down: f_start=32'hFFFF_FFF0, f_step=32'h20, dir=0, step_count=1, dwell=1 -> K_out FFFF_FFF0 then 0000_0010; dir=1 from f_start=5, f_step=10 -> 5 then FFFF_FFFB.
- dwell=0, step_count=0 -> K_out=f_start one cycle, busy 1 cycle, done next edge.
- Continuous: f_start=1, f_step=1, step_count=2, dwell=2, cont=1 -> 1,1,2,2,3,3,1,1,... indefinitely; done never; abort -> busy low next edge, K_out holds.
- Start while busy with different f_start -> ignored, sequence unchanged; start+abort in IDLE -> stays idle.
- Assert rst mid-sweep (async, between edges) -> K_out=0, P_out=0, busy=0 immediately; fresh start after release runs full sweep.
